// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-serial LOAD/STORE responder with alignment/range checks and load extension
module mem_responder #(
  parameter int unsigned DEPTH_BYTES = 'h10000,
  parameter int          ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_width,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int MEM_AW = $clog2(DEPTH_BYTES);

  // one extra bit so addr+N at the top of the address space cannot wrap
  typedef logic [ADDR_W:0] ext_addr_t;
  localparam ext_addr_t DEPTH_EXT = ext_addr_t'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, XFER, RESP, ERR_RESP} state_t;

  state_t            state, state_nxt;
  logic              lat_we, lat_unsigned;
  logic [1:0]        lat_width;
  logic [MEM_AW-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [1:0]        cnt;
  logic [31:0]       rdata_buf;
  logic [31:0]       load_ext;
  logic [7:0]        mem [0:DEPTH_BYTES-1];

  logic              accept, req_bad, last_byte;
  logic [2:0]        req_n;
  logic [1:0]        align_mask, last_idx;
  logic [MEM_AW-1:0] byte_addr;

  assign accept    = req_valid && req_ready;
  assign byte_addr = lat_addr + MEM_AW'(cnt);
  assign last_byte = (cnt == last_idx);

  // request size and legality, evaluated on the raw request inputs at accept time
  always_comb begin
    req_n      = 3'd1;
    align_mask = 2'b00;
    req_bad    = 1'b0;
    case (req_width)
      2'b01:   begin req_n = 3'd2; align_mask = 2'b01; end
      2'b10:   begin req_n = 3'd4; align_mask = 2'b11; end
      default: begin req_n = 3'd1; align_mask = 2'b00; end
    endcase
    if (req_width == 2'b11)
      req_bad = 1'b1;
    else if ((req_addr[1:0] & align_mask) != 2'b00)
      req_bad = 1'b1;
    else if (ext_addr_t'(req_addr) + ext_addr_t'(req_n) > DEPTH_EXT)
      req_bad = 1'b1;
  end

  // index of the final byte of the latched request, and sign/zero extension of the gathered load
  always_comb begin
    last_idx = 2'd0;
    load_ext = rdata_buf;
    case (lat_width)
      2'b00: begin
        last_idx = 2'd0;
        load_ext = {{24{~lat_unsigned & rdata_buf[7]}}, rdata_buf[7:0]};
      end
      2'b01: begin
        last_idx = 2'd1;
        load_ext = {{16{~lat_unsigned & rdata_buf[15]}}, rdata_buf[15:0]};
      end
      default: begin
        last_idx = 2'd3;
        load_ext = rdata_buf;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and handshake outputs; outputs are pure decodes of the state so they hold under backpressure
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    case (state)
      IDLE: begin
        req_ready = ~rst;
        if (accept) state_nxt = req_bad ? ERR_RESP : XFER;
      end
      XFER: begin
        if (last_byte) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = lat_we ? 32'h0 : load_ext;
        if (rsp_ready) state_nxt = IDLE;
      end
      ERR_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // capture the request on accept and step the byte counter during the transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_width    <= 2'b00;
      lat_addr     <= '0;
      lat_wdata    <= 32'h0;
      cnt          <= 2'd0;
    end else if (accept) begin
      lat_we       <= req_we;
      lat_unsigned <= req_unsigned;
      lat_width    <= req_width;
      lat_addr     <= req_addr[MEM_AW-1:0];
      lat_wdata    <= req_wdata;
      cnt          <= 2'd0;
    end else if (state == XFER) begin
      cnt <= cnt + 2'd1;
    end
  end

  // one storage byte per XFER cycle; storage is never cleared by reset
  always_ff @(posedge clk) begin
    if (state == XFER) begin
      if (lat_we) mem[byte_addr] <= lat_wdata[{cnt, 3'b000} +: 8];
      else        rdata_buf[{cnt, 3'b000} +: 8] <= mem[byte_addr];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder against a byte-array model
module tb_mem_responder;

  localparam int unsigned DEPTH = 32'h10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic [7:0]  ref_mem [0:DEPTH-1];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_q[$];
  int          hs_q[$];
  logic [31:0] rd_q[$];

  mem_responder #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (req_valid && req_ready) acc_q.push_back(cyc);
    if (rsp_valid && rsp_ready) begin
      hs_q.push_back(cyc);
      rd_q.push_back(rsp_rdata);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // architectural model: bytes, little-endian, checks in priority order
  function automatic void model(input logic we, input logic [1:0] w, input logic u,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rd, output int lat);
    int unsigned n;
    longint unsigned a64;
    logic [31:0] v;
    n   = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    a64 = addr;
    err = 1'b0;
    rd  = 32'h0;
    if (w == 2'd3) err = 1'b1;
    else if (addr % n != 0) err = 1'b1;
    else if (a64 + n > DEPTH) err = 1'b1;
    lat = err ? 1 : int'(n) + 1;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < int'(n); i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < int'(n); i++) v = v | (32'(ref_mem[addr + i]) << (8*i));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endfunction

  function automatic void poke(input int unsigned a, input logic [7:0] b);
    ref_mem[a] = b;
    dut.mem[a] = b;
  endfunction

  task automatic do_req(input logic we, input logic [1:0] w, input logic u,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input string tag, output logic [31:0] got_rd);
    logic        e_err;
    logic [31:0] e_rd, s_rd;
    logic        s_err;
    int          e_lat, k;
    model(we, w, u, addr, wdata, e_err, e_rd, e_lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_width = w; req_unsigned = u;
    req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // junk on the request port outside IDLE must be ignored
    req_valid = 1'($urandom); req_we = 1'($urandom); req_width = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    k = 1;
    while (!rsp_valid && k < 12) begin @(negedge clk); k++; end
    check({tag, " latency"}, 32'(k), 32'(e_lat));
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(e_err));
    check({tag, " rsp_rdata"}, rsp_rdata, e_rd);
    got_rd = rsp_rdata;
    s_rd = rsp_rdata; s_err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold rdata"}, rsp_rdata, s_rd);
      check({tag, " hold err"}, 32'(rsp_err), 32'(s_err));
      check({tag, " hold ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    check({tag, " post valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " post idle"}, 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      int unsigned idx;
      idx = (addr + i) & (DEPTH - 1);
      check({tag, " mem"}, 32'(dut.mem[idx]), 32'(ref_mem[idx]));
    end
  endtask

  initial begin
    logic [31:0] rd, ea, eb;
    logic        ee;
    int          el, k;
    logic        seen;
    logic [1:0]  w;
    logic [31:0] a;
    int          r;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_width = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) poke(i, 8'($urandom));
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    // word store then load
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, "sw100", rd);
    check("sw100 b0", 32'(dut.mem[32'h100]), 32'hEF);
    check("sw100 b1", 32'(dut.mem[32'h101]), 32'hBE);
    check("sw100 b2", 32'(dut.mem[32'h102]), 32'hAD);
    check("sw100 b3", 32'(dut.mem[32'h103]), 32'hDE);
    check("sw100 rdata", rd, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, "lw100", rd);
    check("lw100 const", rd, 32'hDEADBEEF);

    // extension
    poke(32'h20, 8'h80); poke(32'h21, 8'h00);
    do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0, "lb20", rd);
    check("lb20 const", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 0, "lbu20", rd);
    check("lbu20 const", rd, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0, "lh20", rd);
    check("lh20 const", rd, 32'h00000080);

    // errors
    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 0, "lh21 misalign", rd);
    do_req(1'b1, 2'b10, 1'b0, DEPTH - 2, 32'hCAFEF00D, 0, "sw top misalign", rd);
    do_req(1'b1, 2'b01, 1'b0, DEPTH - 2, 32'h1234ABCD, 0, "sh top ok", rd);
    do_req(1'b1, 2'b10, 1'b0, DEPTH - 4, 32'h0BADF00D, 0, "sw top ok", rd);
    do_req(1'b1, 2'b10, 1'b0, DEPTH, 32'h55AA55AA, 0, "sw depth range", rd);
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, "width11", rd);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 0, "lw wrap", rd);

    // backpressure
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 3, "lw100 bp", rd);

    // reset during a word store
    for (int i = 0; i < 4; i++) poke(32'h40 + i, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_width = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h11223344; rsp_ready = 1'b1;
    check("rstmid ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = rsp_valid;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstmid valid", 32'(rsp_valid), 32'd0);
    check("rstmid req_ready", 32'(req_ready), 32'd0);
    check("rstmid rdata", rsp_rdata, 32'h0);
    hs_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rstmid ready after", 32'(req_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    rsp_ready = 1'b0;
    check("rstmid no rsp", 32'(seen) + 32'(hs_q.size()), 32'd0);
    check("rstmid m40", 32'(dut.mem[32'h40]), 32'h44);
    check("rstmid m41", 32'(dut.mem[32'h41]), 32'h33);
    check("rstmid m42", 32'(dut.mem[32'h42]), 32'h00);
    check("rstmid m43", 32'(dut.mem[32'h43]), 32'h00);
    ref_mem[32'h40] = 8'h44; ref_mem[32'h41] = 8'h33;

    // back-to-back with req_valid held high
    model(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, ee, ea, el);
    model(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, ee, eb, el);
    acc_q.delete(); hs_q.delete(); rd_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_width = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h100; rsp_ready = 1'b1;
    k = 0;
    while (acc_q.size() < 1 && k < 30) begin @(negedge clk); k++; end
    req_width = 2'b00; req_addr = 32'h20;
    k = 0;
    while (acc_q.size() < 2 && k < 30) begin @(negedge clk); k++; end
    req_valid = 1'b0;
    k = 0;
    while (hs_q.size() < 2 && k < 30) begin @(negedge clk); k++; end
    rsp_ready = 1'b0;
    check("b2b accepts", 32'(acc_q.size()), 32'd2);
    check("b2b handshakes", 32'(hs_q.size()), 32'd2);
    if (acc_q.size() == 2 && hs_q.size() == 2) begin
      check("b2b gap", 32'(acc_q[1] - hs_q[0] >= 1), 32'd1);
      check("b2b rdata0", rd_q[0], ea);
      check("b2b rdata1", rd_q[1], eb);
    end

    // randomized traffic
    for (int t = 0; t < 120; t++) begin
      r = $urandom_range(0, 9);
      w = (r == 9) ? 2'b11 : 2'(r % 3);
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 255);
        1:       a = DEPTH - 8 + $urandom_range(0, 15);
        2:       a = 32'hFFFFFFF0 + $urandom_range(0, 15);
        default: a = $urandom_range(0, DEPTH - 1);
      endcase
      do_req(1'($urandom), w, 1'($urandom), a, $urandom, $urandom_range(0, 2), "rand", rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's multi-cycle control FSM.
- Serves LOAD/STORE requests of 8/16/32 bits against byte-organised storage, moving one byte per cycle, little-endian.
- Checks alignment and range before touching storage.
- Performs load sign/zero extension so the control FSM writes the response straight into the register file.

Parameters:
- DEPTH_BYTES, 'h10000, storage size in bytes; valid addresses are 0..DEPTH_BYTES-1.
- ADDR_W, 32, request address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_width  in  2  RISC-V funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  funct3[2]: 1 = zero-extend load (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low N bytes used.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected (misaligned, out of range, or illegal width).

Behaviour:
- One clock; reset is asynchronous and active-high.
- While rst is high: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, byte counter=0. Storage contents are not cleared.
- States and transitions:
  - IDLE: req_ready=1. On req_valid && req_ready, latch we/width/unsigned/addr/wdata, then:
    - to ERR_RESP if the request fails the checks below;
    - otherwise to XFER with counter=0.
  - XFER: req_ready=0. Each cycle accesses byte addr+counter.
    - Store: mem[addr+counter] <= wdata byte[counter].
    - Load: rdata byte[counter] <= mem[addr+counter].
    - counter increments each cycle; after byte N-1, go to RESP.
  - RESP / ERR_RESP: rsp_valid=1. rsp_rdata, rsp_err and rsp_valid are held stable until rsp_ready=1; on that cycle go to IDLE.
- N = 1/2/4 for width 00/01/10.
- Request checks, in priority order; any failure sets rsp_err=1 and rsp_rdata=0:
  - width 11 → illegal.
  - addr mod N != 0 → misaligned.
  - addr+N > DEPTH_BYTES, computed at ADDR_W+1 bits so 'hFFFFFFFF does not wrap → out of range.
  - Errored requests never touch storage.
- Load extension:
  - byte: bit 7 replicated into [31:8], or zeros if req_unsigned.
  - half: bit 15 replicated into [31:16], or zeros if req_unsigned.
  - word: req_unsigned ignored.
- Stores: rsp_rdata=0, rsp_err=0; the response still handshakes.
- Latency, with the accept edge at cycle T:
  - legal request: rsp_valid first high at T+N+1;
  - error: rsp_valid first high at T+1.
- Throughput: req_ready is high only in IDLE, so back-to-back requests have at least one idle cycle after each response handshake.
- Inputs other than rsp_ready are ignored outside IDLE, including req_valid.
- Reset mid-XFER aborts immediately:
  - store bytes already written remain written; unwritten bytes keep their old value;
  - no response is produced for the aborted request.
- Storage is an internal byte array named mem. The bench may preload it hierarchically.

Test Plan:
- Word store then load: store addr 'h100, wdata 'hDEADBEEF; then LW 'h100.
  - → mem[100..103] = EF,BE,AD,DE;
  - → rdata 'hDEADBEEF, err=0;
  - → rsp_valid at T+5 for each request.
- Sign extension: mem['h20]='h80.
  - LB 'h20 → 'hFFFFFF80.
  - LBU 'h20 → 'h00000080.
  - LH 'h20 with mem['h21]='h00 → 'h00000080.
  - Each responds at T+2 (byte) or T+3 (half).
- Errors: each error → rsp_valid at T+1 with err=1, rdata=0.
  - LH 'h21 → err, and mem unchanged.
  - SW DEPTH_BYTES-2 → err, and no write.
  - width 11 → err.
  - LW 'hFFFFFFFC → err, with no wrap to a valid address.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid rises on LW 'h100.
  - → rdata and err stable throughout;
  - → req_ready=0 throughout;
  - → IDLE on the cycle after rsp_ready rises.
- Reset mid-store: mem['h40..43]=0; SW 'h40, 'h11223344; assert rst after 2 XFER cycles.
  - → mem['h40..43] = 44,33,00,00;
  - → rsp_valid never rises;
  - → req_ready=1 on the first clock after rst falls.
- Back-to-back: req_valid held high with two loads queued.
  - → second accept no earlier than one cycle after the first response handshake.
